// File: rtl/hs_channel_buf.sv
// Valid/ready channel buffer: a DEPTH-entry circular FIFO with registered handshake outputs,
// optional dropping of all-zero beats and a wrapping count of downstream transfers.
module hs_channel_buf #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DROP_ZERO = 0,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [AW:0]       count,
  output logic [15:0]       xfer_cnt
);

  localparam logic [AW:0]   CntFull = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CntOne  = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne  = AW'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, w_wr_ptr;
  logic [AW-1:0]     r_rd_ptr, w_rd_ptr;
  logic [AW:0]       r_count, w_count;
  logic [15:0]       r_xfer, w_xfer;
  // Held low through reset so s_ready stays 0 until the first edge after release.
  logic              r_live;
  logic              w_in_hs, w_out_hs, w_store;

  assign s_ready  = r_live && (r_count != CntFull);
  assign m_valid  = (r_count != '0);
  // Gated so unwritten storage never leaks X onto the output.
  assign m_data   = m_valid ? r_mem[r_rd_ptr] : '0;
  assign count    = r_count;
  assign xfer_cnt = r_xfer;

  assign w_in_hs  = s_valid && s_ready;
  assign w_out_hs = m_valid && m_ready;
  assign w_store  = w_in_hs && ((DROP_ZERO == 0) || (s_data != '0));

  always_comb begin
    w_wr_ptr = r_wr_ptr;
    w_rd_ptr = r_rd_ptr;
    w_count  = r_count;
    w_xfer   = r_xfer;
    if (w_store) begin
      w_wr_ptr = r_wr_ptr + PtrOne;
    end
    if (w_out_hs) begin
      w_rd_ptr = r_rd_ptr + PtrOne;
      w_xfer   = r_xfer + 16'd1;
    end
    unique case ({w_store, w_out_hs})
      2'b10:   w_count = r_count + CntOne;
      2'b01:   w_count = r_count - CntOne;
      default: w_count = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_xfer   <= '0;
      r_live   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr;
      r_rd_ptr <= w_rd_ptr;
      r_count  <= w_count;
      r_xfer   <= w_xfer;
      r_live   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

endmodule

// File: tb/tb_hs_channel_buf.sv
// Bench for hs_channel_buf: two instances (DROP_ZERO=0 and 1) share the stimulus, each with its
// own scoreboard queue of expected output beats.
module tb_hs_channel_buf;

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic [31:0] s_data;
  logic        m_ready;

  logic        s_ready, m_valid;
  logic [31:0] m_data;
  logic [2:0]  count;
  logic [15:0] xfer_cnt;

  logic        z_s_ready, z_m_valid;
  logic [31:0] z_m_data;
  logic [2:0]  z_count;
  logic [15:0] z_xfer_cnt;

  logic [31:0] exp_q[$];
  logic [31:0] z_q[$];
  int          n_vec;
  int          n_bad;

  hs_channel_buf #(.DATA_W(32), .DEPTH(4), .DROP_ZERO(0)) u_dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .count(count), .xfer_cnt(xfer_cnt)
  );

  hs_channel_buf #(.DATA_W(32), .DEPTH(4), .DROP_ZERO(1)) u_dut_dz (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(z_s_ready),
    .m_valid(z_m_valid), .m_data(z_m_data), .m_ready(m_ready), .count(z_count),
    .xfer_cnt(z_xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (got hang, want finish)");
    $fatal(1);
  end

  // One clock: sample at the negedge, score handshakes, advance past the rising edge.
  task automatic step(output logic acc);
    logic [31:0] e;
    @(negedge clk);
    acc = s_valid && s_ready;
    n_vec++;
    if (m_valid !== (exp_q.size() != 0)) begin
      n_bad++;
      $display("FAIL m_valid_model: got %b want %b", m_valid, exp_q.size() != 0);
    end
    if (m_valid && m_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL m_data_order: got unexpected beat %h want none", m_data);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e) begin
          n_bad++;
          $display("FAIL m_data_order: got %h want %h", m_data, e);
        end
      end
    end
    if (z_m_valid && m_ready) begin
      n_vec++;
      if (z_q.size() == 0) begin
        n_bad++;
        $display("FAIL dz_data_order: got unexpected beat %h want none", z_m_data);
      end else begin
        e = z_q.pop_front();
        if (z_m_data !== e) begin
          n_bad++;
          $display("FAIL dz_data_order: got %h want %h", z_m_data, e);
        end
      end
    end
    if (acc) exp_q.push_back(s_data);
    if (s_valid && z_s_ready && (s_data != 32'h0)) z_q.push_back(s_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    s_valid = 1'b0;
    s_data  = 32'h0;
    m_ready = 1'b0;
    reset   = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (count !== 3'd0 || m_valid !== 1'b0 || s_ready !== 1'b0 || xfer_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_state: got count=%0d m_valid=%b s_ready=%b xfer=%0d want 0 0 0 0",
               count, m_valid, s_ready, xfer_cnt);
    end
    n_vec++;
    if (m_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_m_data: got %h want 0", m_data);
    end
    #9 reset = 1'b1;
    #1;
    n_vec++;
    if (s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_before_edge: got %b want 0", s_ready);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (s_ready !== 1'b1 || z_s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_release: got %b/%b want 1/1", s_ready, z_s_ready);
    end
  endtask

  task automatic test_single();
    logic acc;
    s_valid = 1'b1;
    s_data  = 32'hA5A5_0001;
    m_ready = 1'b1;
    step(acc);
    s_valid = 1'b0;
    n_vec++;
    if (m_valid !== 1'b1 || m_data !== 32'hA5A5_0001 || count !== 3'd1) begin
      n_bad++;
      $display("FAIL single_latency: got v=%b d=%h c=%0d want 1 a5a50001 1",
               m_valid, m_data, count);
    end
    step(acc);
    n_vec++;
    if (count !== 3'd0 || xfer_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL single_done: got count=%0d xfer=%0d want 0 1", count, xfer_cnt);
    end
  endtask

  task automatic test_fill();
    logic acc;
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_data = 32'(k + 1);
      step(acc);
    end
    n_vec++;
    if (count !== 3'd4 || s_ready !== 1'b0 || m_data !== 32'd1) begin
      n_bad++;
      $display("FAIL full_state: got count=%0d s_ready=%b m_data=%h want 4 0 1",
               count, s_ready, m_data);
    end
    m_ready = 1'b1;
    step(acc);
    n_vec++;
    if (acc !== 1'b0 || count !== 3'd3 || s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL full_pop: got acc=%b count=%0d s_ready=%b want 0 3 1", acc, count, s_ready);
    end
    for (int k = 0; k < 10; k++) begin
      step(acc);
      if (acc) s_valid = 1'b0;
    end
    n_vec++;
    if (count !== 3'd0 || xfer_cnt !== 16'd6 || s_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_drain: got count=%0d xfer=%0d pending=%b want 0 6 0",
               count, xfer_cnt, s_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = 32'h100 + 32'(i);
      step(acc);
      n_vec++;
      if (acc !== 1'b1 || count !== 3'd1) begin
        n_bad++;
        $display("FAIL stream_beat%0d: got acc=%b count=%0d want 1 1", i, acc, count);
      end
    end
    s_valid = 1'b0;
    step(acc);
    n_vec++;
    if (count !== 3'd0 || xfer_cnt !== 16'd26) begin
      n_bad++;
      $display("FAIL stream_total: got count=%0d xfer=%0d want 0 26", count, xfer_cnt);
    end
  endtask

  task automatic test_drop_zero();
    logic        acc;
    logic [15:0] base;
    logic [15:0] zbase;
    logic [31:0] pat [3];
    pat[0] = 32'd7;
    pat[1] = 32'd0;
    pat[2] = 32'd9;
    base  = xfer_cnt;
    zbase = z_xfer_cnt;
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = pat[i];
      step(acc);
    end
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) step(acc);
    n_vec++;
    if (16'(xfer_cnt - base) !== 16'd3) begin
      n_bad++;
      $display("FAIL keep_zero_xfer: got %0d want 3", 16'(xfer_cnt - base));
    end
    n_vec++;
    if (16'(z_xfer_cnt - zbase) !== 16'd2) begin
      n_bad++;
      $display("FAIL drop_zero_xfer: got %0d want 2", 16'(z_xfer_cnt - zbase));
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 32'h31 + 32'(i);
      step(acc);
    end
    s_valid = 1'b0;
    n_vec++;
    if (count !== 3'd3) begin
      n_bad++;
      $display("FAIL pre_reset_count: got %0d want 3", count);
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (m_valid !== 1'b0 || count !== 3'd0 || z_count !== 3'd0 || s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b c=%0d zc=%0d r=%b want 0 0 0 0",
               m_valid, count, z_count, s_ready);
    end
    exp_q.delete();
    z_q.delete();
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data  = 32'h55;
    m_ready = 1'b1;
    step(acc);
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) step(acc);
    n_vec++;
    if (xfer_cnt !== 16'd1 || z_xfer_cnt !== 16'd1 || count !== 3'd0) begin
      n_bad++;
      $display("FAIL post_reset: got xfer=%0d zxfer=%0d count=%0d want 1 1 0",
               xfer_cnt, z_xfer_cnt, count);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_drop_zero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
